// File: rtl/reg_writeback_unit.sv
// Register-file write-side driver for the multi-cycle CPU: selects destination/data,
// waits for load data, issues one write strobe per instruction. Optional macro WB_FWD_EN.
module reg_writeback_unit #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic             req_load,
    input  logic [4:0]       req_rt,
    input  logic [4:0]       req_rd,
    input  logic [31:0]      req_pc,
    input  logic [31:0]      req_alu,
    input  logic             mem_valid,
    input  logic [31:0]      mem_rdata,
    output logic             wr_en,
    output logic [4:0]       wr_addr,
    output logic [31:0]      wr_data,
    output logic             load_err,
    output logic [CNT_W-1:0] wr_count,
    input  logic [4:0]       fwd_addr,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_WRITE    = 2'b10
    } state_t;

    // Timeout fires on the edge that completes the MEM_TIMEOUT-th WAIT_MEM cycle.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t             state_r;
    state_t             req_next_s;
    logic [4:0]         req_dest_s;
    logic [31:0]        req_data_s;
    logic [4:0]         pend_dest_r;
    logic [31:0]        pend_data_r;
    logic [7:0]         tmo_cnt_r;
    logic               req_ready_r;
    logic               wr_en_r;
    logic [4:0]         wr_addr_r;
    logic [31:0]        wr_data_r;
    logic               load_err_r;
    logic [CNT_W-1:0]   wr_count_r;

    // Decode the incoming request into destination, data and follow-on state.
    always_comb begin
        req_dest_s = 5'd0;
        req_data_s = req_alu;
        req_next_s = ST_IDLE;
        case (req_kind)
            2'b00: begin
                req_dest_s = 5'd31;
                req_data_s = req_pc + 32'd4;
                req_next_s = ST_WRITE;
            end
            2'b01: begin
                req_dest_s = req_rt;
                if (req_load) begin
                    req_next_s = ST_WAIT_MEM;
                end else begin
                    req_next_s = ST_WRITE;
                end
            end
            2'b10: begin
                req_dest_s = req_rd;
                req_next_s = ST_WRITE;
            end
            default: begin
                req_dest_s = 5'd0;
                req_next_s = ST_IDLE;
            end
        endcase
    end

    // Writeback state machine with registered strobe, address, data and status.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            pend_dest_r <= 5'd0;
            pend_data_r <= 32'd0;
            tmo_cnt_r   <= 8'd0;
            req_ready_r <= 1'b1;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= 5'd0;
            wr_data_r   <= 32'd0;
            load_err_r  <= 1'b0;
            wr_count_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        tmo_cnt_r <= 8'd0;
                        case (req_next_s)
                            ST_WRITE: begin
                                pend_dest_r <= req_dest_s;
                                pend_data_r <= req_data_s;
                                wr_en_r     <= (req_dest_s != 5'd0);
                                wr_addr_r   <= req_dest_s;
                                wr_data_r   <= req_data_s;
                                req_ready_r <= 1'b0;
                                state_r     <= ST_WRITE;
                            end
                            ST_WAIT_MEM: begin
                                pend_dest_r <= req_dest_s;
                                pend_data_r <= 32'd0;
                                req_ready_r <= 1'b0;
                                state_r     <= ST_WAIT_MEM;
                            end
                            default: begin
                                state_r <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_WAIT_MEM: begin
                    // Data arriving on the expiry cycle still wins over the timeout.
                    if (mem_valid) begin
                        pend_data_r <= mem_rdata;
                        wr_en_r     <= (pend_dest_r != 5'd0);
                        wr_addr_r   <= pend_dest_r;
                        wr_data_r   <= mem_rdata;
                        state_r     <= ST_WRITE;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        load_err_r  <= 1'b1;
                        tmo_cnt_r   <= 8'd0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (wr_en_r) begin
                        wr_count_r <= wr_count_r + CNT_W'(1);
                    end
                    wr_en_r     <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    wr_en_r     <= 1'b0;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign load_err  = load_err_r;
    assign wr_count  = wr_count_r;

`ifdef WB_FWD_EN
    // Pending data only exists once the state machine sits in WRITE.
    logic fwd_match_s;
    assign fwd_match_s = (state_r == ST_WRITE) && (pend_dest_r != 5'd0) && (pend_dest_r == fwd_addr);
    assign fwd_hit     = fwd_match_s;
    assign fwd_data    = fwd_match_s ? pend_data_r : 32'd0;
`else
    logic fwd_unused_s;
    assign fwd_unused_s = ^{fwd_addr, pend_data_r};
    assign fwd_hit      = 1'b0;
    assign fwd_data     = 32'd0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: expected writes are queued at issue time
// and a negedge monitor pops and compares every wr_en pulse.
module tb_reg_writeback_unit;

    logic        CLK;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic        req_load;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [31:0] req_pc;
    logic [31:0] req_alu;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        load_err;
    logic [15:0] wr_count;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int checks;
    int errors;
    logic [36:0] exp_q[$];

    reg_writeback_unit #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_load(req_load), .req_rt(req_rt), .req_rd(req_rd),
        .req_pc(req_pc), .req_alu(req_alu),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_err(load_err), .wr_count(wr_count),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, none expected", wr_addr, wr_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors = errors + 1;
                    $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                             wr_addr, wr_data, e[36:32], e[31:0]);
                end
            end
        end
    end

    // Present one request when ready; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] kind, input logic load, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu);
        int n;
        n = 0;
        @(negedge CLK);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n = n + 1;
        end
        if (n >= 20) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
        end
        req_valid = 1'b1;
        req_kind  = kind;
        req_load  = load;
        req_rt    = rt;
        req_rd    = rd;
        req_pc    = pc;
        req_alu   = alu;
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    initial begin
        logic exp_fwd;
        checks = 0;
        errors = 0;
`ifdef WB_FWD_EN
        exp_fwd = 1'b1;
`else
        exp_fwd = 1'b0;
`endif
        Reset = 1'b1;
        req_valid = 1'b0; req_kind = 2'b11; req_load = 1'b0; req_rt = 5'd0; req_rd = 5'd0;
        req_pc = 32'd0; req_alu = 32'd0; mem_valid = 1'b0; mem_rdata = 32'd0; fwd_addr = 5'd0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        Reset = 1'b0;

        // R-type: strobe in the cycle after acceptance, ready again one cycle later
        exp_q.push_back({5'd5, 32'h0000_1234});
        issue(2'b10, 1'b0, 5'd0, 5'd5, 32'd0, 32'h0000_1234);
        chk("rtype_wr_en", 32'(wr_en), 32'd1);
        chk("rtype_ready_busy", 32'(req_ready), 32'd0);
        @(negedge CLK);
        chk("rtype_count", 32'(wr_count), 32'd1);
        chk("rtype_ready_back", 32'(req_ready), 32'd1);
        chk("rtype_wr_en_low", 32'(wr_en), 32'd0);
        chk("rtype_addr_hold", 32'(wr_addr), 32'd5);

        // Forwarding lookup during WRITE
        exp_q.push_back({5'd7, 32'hCAFE_0007});
        issue(2'b10, 1'b0, 5'd0, 5'd7, 32'd0, 32'hCAFE_0007);
        fwd_addr = 5'd7;
        #1;
        chk("fwd_hit_7", 32'(fwd_hit), 32'(exp_fwd));
        chk("fwd_data_7", fwd_data, exp_fwd ? 32'hCAFE_0007 : 32'd0);
        fwd_addr = 5'd8;
        #1;
        chk("fwd_hit_8", 32'(fwd_hit), 32'd0);
        chk("fwd_data_8", fwd_data, 32'd0);

        // Link, including PC+4 wraparound
        exp_q.push_back({5'd31, 32'h0040_0014});
        issue(2'b00, 1'b0, 5'd3, 5'd4, 32'h0040_0010, 32'h1111_1111);
        exp_q.push_back({5'd31, 32'h0000_0000});
        issue(2'b00, 1'b0, 5'd3, 5'd4, 32'hFFFF_FFFC, 32'h1111_1111);
        @(negedge CLK);
        chk("link_count", 32'(wr_count), 32'd4);

        // Load completing after three WAIT_MEM cycles
        exp_q.push_back({5'd9, 32'hDEAD_BEEF});
        issue(2'b01, 1'b1, 5'd9, 5'd2, 32'd0, 32'h0000_0055);
        fwd_addr = 5'd9;
        #1;
        chk("fwd_wait_nodata", 32'(fwd_hit), 32'd0);
        repeat (2) @(negedge CLK);
        chk("load_ready_busy", 32'(req_ready), 32'd0);
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        mem_valid = 1'b0;
        chk("load_wr_en", 32'(wr_en), 32'd1);
        @(negedge CLK);
        chk("load_err_clear", 32'(load_err), 32'd0);
        chk("load_count", 32'(wr_count), 32'd5);

        // Stray mem_valid in IDLE, then load timeout after 8 WAIT_MEM cycles
        mem_valid = 1'b1;
        @(negedge CLK);
        mem_valid = 1'b0;
        issue(2'b01, 1'b1, 5'd10, 5'd0, 32'd0, 32'd0);
        repeat (7) @(negedge CLK);
        chk("tmo_err_early", 32'(load_err), 32'd0);
        chk("tmo_busy", 32'(req_ready), 32'd0);
        @(negedge CLK);
        chk("tmo_err_set", 32'(load_err), 32'd1);
        chk("tmo_ready", 32'(req_ready), 32'd1);
        chk("tmo_count", 32'(wr_count), 32'd5);

        // Write to $0 suppressed; kind 11 retires without a WRITE cycle
        issue(2'b01, 1'b0, 5'd0, 5'd6, 32'd0, 32'h0000_0099);
        chk("zero_busy", 32'(req_ready), 32'd0);
        @(negedge CLK);
        chk("zero_count", 32'(wr_count), 32'd5);
        issue(2'b11, 1'b1, 5'd3, 5'd3, 32'd0, 32'h0000_0077);
        chk("nowrite_ready", 32'(req_ready), 32'd1);
        chk("nowrite_count", 32'(wr_count), 32'd5);

        // req_load ignored for R-type; sticky error survives
        exp_q.push_back({5'd12, 32'h0BAD_F00D});
        issue(2'b10, 1'b1, 5'd1, 5'd12, 32'd0, 32'h0BAD_F00D);
        @(negedge CLK);
        chk("rload_count", 32'(wr_count), 32'd6);
        chk("err_sticky", 32'(load_err), 32'd1);

        // Reset while waiting on memory drops the pending load
        issue(2'b01, 1'b1, 5'd11, 5'd0, 32'd0, 32'd0);
        Reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_count", 32'(wr_count), 32'd0);
        chk("mid_rst_err", 32'(load_err), 32'd0);
        chk("mid_rst_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_data", wr_data, 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge CLK);
        mem_valid = 1'b0;
        repeat (2) @(negedge CLK);
        chk("post_rst_count", 32'(wr_count), 32'd0);
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        repeat (3) @(negedge CLK);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
